// File: rtl/rv_pkg.sv
// Shared constants and types for the RV core datapath.
// Register-file widths default to these values.
package rv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = $clog2(NREGS);

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] xword_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: tracks pending writes, produces the issue hazard check
// and flags write-backs to registers that had no pending write.
module reg_scoreboard #(
    parameter int unsigned NREGS  = rv_pkg::NREGS,
    parameter int unsigned AW     = $clog2(NREGS),
    parameter bit          BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    rs1_addr,
    input  logic             rs1_pc_sel,
    input  logic [AW-1:0]    rs2_addr,
    input  logic             iss_valid,
    input  logic             iss_rs1_use,
    input  logic             iss_rs2_use,
    input  logic             iss_wr,
    input  logic [AW-1:0]    iss_rd,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    output logic             iss_ready,
    output logic [NREGS-1:0] busy_vec,
    output logic             wb_err
);

    import rv_pkg::*;

    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] wb_hit;
    logic [NREGS-1:0] eb;
    logic             wb_err_q, wb_err_d;
    logic             hazard;
    logic             fire;

    always_comb begin
        wb_hit = '0;
        if (wb_valid && (wb_rd != '0)) begin
            wb_hit[wb_rd] = 1'b1;
        end
    end

    // A write-back landing this cycle resolves the hazard only if its data is forwarded.
    always_comb begin
        if (BYPASS) begin
            eb = busy_q & ~wb_hit;
        end else begin
            eb = busy_q;
        end
    end

    always_comb begin
        hazard    = (iss_rs1_use & ~rs1_pc_sel & eb[rs1_addr])
                  | (iss_rs2_use & eb[rs2_addr])
                  | (iss_wr & eb[iss_rd]);
        iss_ready = ~hazard;
        fire      = iss_valid & iss_ready;
    end

    // Clear first, then set, so a same-cycle allocation keeps the register busy.
    always_comb begin
        busy_d = busy_q & ~wb_hit;
        if (fire && iss_wr && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        wb_err_d  = wb_valid && (wb_rd != '0) && !busy_q[wb_rd];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign busy_vec = busy_q;
    assign wb_err   = wb_err_q;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with two read ports, one write-back port, optional
// write-to-read bypass and a busy scoreboard for decode hazard stalls.
module reg_file_sb #(
    parameter int unsigned XLEN   = rv_pkg::XLEN,
    parameter int unsigned NREGS  = rv_pkg::NREGS,
    parameter int unsigned AW     = $clog2(NREGS),
    parameter bit          BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    rs1_addr,
    input  logic             rs1_pc_sel,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic             iss_valid,
    input  logic             iss_rs1_use,
    input  logic             iss_rs2_use,
    input  logic             iss_wr,
    input  logic [AW-1:0]    iss_rd,
    output logic             iss_ready,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic [NREGS-1:0] busy_vec,
    output logic             wb_err
);

    import rv_pkg::*;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wb_we;

    assign wb_we = wb_valid && (wb_rd != '0);

    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wb_we) begin
            regs_d[wb_rd] = wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        if (rs1_pc_sel) begin
            rs1_data = pc_in;
        end else if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (BYPASS && wb_valid && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = regs_q[rs1_addr];
        end
    end

    always_comb begin
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (BYPASS && wb_valid && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = regs_q[rs2_addr];
        end
    end

    reg_scoreboard #(
        .NREGS  (NREGS),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .reset_n     (reset_n),
        .rs1_addr    (rs1_addr),
        .rs1_pc_sel  (rs1_pc_sel),
        .rs2_addr    (rs2_addr),
        .iss_valid   (iss_valid),
        .iss_rs1_use (iss_rs1_use),
        .iss_rs2_use (iss_rs2_use),
        .iss_wr      (iss_wr),
        .iss_rd      (iss_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .iss_ready   (iss_ready),
        .busy_vec    (busy_vec),
        .wb_err      (wb_err)
    );

endmodule
